// File: rtl/seven_seg_scanner.sv
// Six-digit multiplexed 7-segment driver (HH MM SS) with a sequential BCD converter.
// Optional blink on buzzer activity is compiled in with `define SEG_BLINK_EN.
module seven_seg_scanner #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hour_format,
  input  logic       is_pm,
  input  logic [7:0] display_hour,
  input  logic [7:0] display_min,
  input  logic [7:0] display_sec,
  input  logic       timer_running,
  input  logic [7:0] timer_min,
  input  logic [7:0] timer_sec,
  input  logic       alarm_buzzer,
  input  logic       timer_buzzer,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {IDLE, CONV_H, CONV_M, CONV_S, DONE} conv_state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  logic [PW-1:0] prescaler;
  logic [2:0]    digit_idx;
  logic          scan_tc, frame_start;

  assign scan_tc     = (prescaler == PW'(SCAN_DIV - 1));
  assign frame_start = scan_tc && (digit_idx == 3'd5);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      digit_idx <= 3'd0;
    end else if (scan_tc) begin
      prescaler <= '0;
      digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  conv_state_t state, state_nxt;
  logic [7:0]  work, hold_m, hold_s;
  logic [3:0]  tens;
  logic        snap_timer, snap_12h, snap_pm;
  logic        field_done;
  logic [6:0]  code_hi, code_lo;
  logic [6:0]  res   [6];
  logic [6:0]  digit [6];
  logic [5:0]  dp_mask;

  // Values above 99 are never reduced, so the range check doubles as the dash detector.
  assign field_done = (work < 8'd10) || (work > 8'd99);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = CONV_H;
      CONV_H:  if (field_done) state_nxt = CONV_M;
      CONV_M:  if (field_done) state_nxt = CONV_S;
      CONV_S:  if (field_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    code_hi = seg_of(tens);
    code_lo = seg_of(work[3:0]);
    if (work > 8'd99) begin
      code_hi = SEG_DASH;
      code_lo = SEG_DASH;
    end else if (state == CONV_H && snap_12h && tens == 4'd0) begin
      code_hi = SEG_BLANK;
    end
    if (state == CONV_H && snap_timer) begin
      code_hi = SEG_BLANK;
      code_lo = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work       <= '0;
      tens       <= '0;
      hold_m     <= '0;
      hold_s     <= '0;
      snap_timer <= 1'b0;
      snap_12h   <= 1'b0;
      snap_pm    <= 1'b0;
      dp_mask    <= '0;
      for (int i = 0; i < 6; i++) begin
        res[i]   <= SEG_BLANK;
        digit[i] <= SEG_BLANK;
      end
    end else begin
      case (state)
        IDLE: if (frame_start) begin
          snap_timer <= timer_running;
          snap_12h   <= hour_format;
          snap_pm    <= is_pm;
          work       <= timer_running ? 8'd0 : display_hour;
          hold_m     <= timer_running ? timer_min : display_min;
          hold_s     <= timer_running ? timer_sec : display_sec;
          tens       <= '0;
        end
        CONV_H, CONV_M, CONV_S: begin
          if (!field_done) begin
            work <= work - 8'd10;
            tens <= tens + 4'd1;
          end else begin
            tens <= '0;
            case (state)
              CONV_H: begin res[0] <= code_hi; res[1] <= code_lo; work <= hold_m; end
              CONV_M: begin res[2] <= code_hi; res[3] <= code_lo; work <= hold_s; end
              default: begin res[4] <= code_hi; res[5] <= code_lo; work <= '0; end
            endcase
          end
        end
        DONE: begin
          for (int i = 0; i < 6; i++) digit[i] <= res[i];
          dp_mask <= snap_timer ? 6'b001000 : {snap_12h & snap_pm, 5'b01010};
        end
        default: ;
      endcase
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (alarm_buzzer | timer_buzzer) begin
        if (frame_cnt == FW'(BLINK_DIV - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end else begin
        frame_cnt   <= '0;
        blink_phase <= 1'b0;
      end
    end
  end
`else
  logic unused_buzz;
  assign unused_buzz = alarm_buzzer ^ timer_buzzer;
`endif

  logic [6:0] cur_seg;
  logic       cur_dp_on;

  always_comb begin
    cur_seg   = SEG_BLANK;
    cur_dp_on = 1'b0;
    case (digit_idx)
      3'd0: begin cur_seg = digit[0]; cur_dp_on = dp_mask[0]; end
      3'd1: begin cur_seg = digit[1]; cur_dp_on = dp_mask[1]; end
      3'd2: begin cur_seg = digit[2]; cur_dp_on = dp_mask[2]; end
      3'd3: begin cur_seg = digit[3]; cur_dp_on = dp_mask[3]; end
      3'd4: begin cur_seg = digit[4]; cur_dp_on = dp_mask[4]; end
      3'd5: begin cur_seg = digit[5]; cur_dp_on = dp_mask[5]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= 6'h3F;
    end else begin
      an  <= ~(6'b100000 >> digit_idx);
      seg <= cur_seg;
      dp  <= ~cur_dp_on;
`ifdef SEG_BLINK_EN
      if (blink_phase) begin
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized self-checking bench for seven_seg_scanner against an arithmetic display model.
module tb_seven_seg_scanner;
  localparam int SD    = 6;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hour_format = 1'b0, is_pm = 1'b0, timer_running = 1'b0;
  logic [7:0] display_hour = 8'd0, display_min = 8'd0, display_sec = 8'd0;
  logic [7:0] timer_min = 8'd0, timer_sec = 8'd0;
  logic       alarm_buzzer = 1'b0, timer_buzzer = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  int n_checks = 0;
  int n_fail   = 0;
  bit an_chk   = 1'b0;

  logic [6:0] enc [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [6:0] exp_seg [6];
  logic       exp_dp  [6];
  logic [6:0] cap_seg [6];
  logic       cap_dp  [6];
  bit         cap_seen[6];

  seven_seg_scanner #(.SCAN_DIV(SD), .BLINK_DIV(2)) dut (
    .clk(clk), .reset(reset), .hour_format(hour_format), .is_pm(is_pm),
    .display_hour(display_hour), .display_min(display_min), .display_sec(display_sec),
    .timer_running(timer_running), .timer_min(timer_min), .timer_sec(timer_sec),
    .alarm_buzzer(alarm_buzzer), .timer_buzzer(timer_buzzer),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (an_chk) begin
      n_checks++;
      if ($countones(~an) != 1) begin
        n_fail++;
        $display("FAIL an_onehot: an=%b, required exactly one low bit", an);
      end
    end
  end

  // Expected display computed directly from decimal arithmetic on the inputs.
  task automatic model(input bit tr, input bit h12, input bit pm, input int hr, input int mn, input int sc);
    int f [3];
    f[0] = hr; f[1] = mn; f[2] = sc;
    for (int k = 0; k < 3; k++) begin
      if (k == 0 && tr) begin
        exp_seg[0] = 7'h7F; exp_seg[1] = 7'h7F;
      end else if (f[k] > 99) begin
        exp_seg[2*k] = 7'h3F; exp_seg[2*k+1] = 7'h3F;
      end else begin
        exp_seg[2*k]   = enc[f[k] / 10];
        exp_seg[2*k+1] = enc[f[k] % 10];
        if (k == 0 && h12 && (f[k] / 10) == 0) exp_seg[0] = 7'h7F;
      end
    end
    for (int k = 0; k < 6; k++) exp_dp[k] = 1'b1;
    exp_dp[3] = 1'b0;
    if (!tr) begin
      exp_dp[1] = 1'b0;
      if (h12 && pm) exp_dp[5] = 1'b0;
    end
  endtask

  task automatic drive(input bit tr, input bit h12, input bit pm, input int hr, input int mn, input int sc);
    timer_running = tr; hour_format = h12; is_pm = pm;
    if (tr) begin
      timer_min = 8'(mn); timer_sec = 8'(sc);
      display_hour = 8'($urandom_range(0, 23)); display_min = 8'($urandom_range(0, 59));
      display_sec = 8'($urandom_range(0, 59));
    end else begin
      display_hour = 8'(hr); display_min = 8'(mn); display_sec = 8'(sc);
      timer_min = 8'($urandom_range(0, 99)); timer_sec = 8'($urandom_range(0, 59));
    end
    model(tr, h12, pm, hr, mn, sc);
  endtask

  task automatic settle();
    repeat (3 * FRAME + 40) @(negedge clk);
  endtask

  task automatic capture();
    for (int k = 0; k < 6; k++) cap_seen[k] = 1'b0;
    repeat (FRAME) begin
      @(negedge clk);
      for (int k = 0; k < 6; k++)
        if (an[5-k] == 1'b0) begin
          cap_seg[k] = seg; cap_dp[k] = dp; cap_seen[k] = 1'b1;
        end
    end
  endtask

  task automatic test_reset(input int delay);
    int  cnt0;
    bit  found;
    logic [5:0] prev;
    drive(1'b0, 1'b0, 1'b0, 23, 59, 57);
    found = 1'b0;
    prev = an;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      @(negedge clk);
      if (an == 6'b011111 && prev != 6'b011111) found = 1'b1;
      prev = an;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_frame_wait: no frame start seen, an=%b", an);
    end
    repeat (delay) @(negedge clk);
    an_chk = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (seg !== 7'h7F || an !== 6'h3F || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_immediate: seg=%h an=%h dp=%b, required 7f 3f 1", seg, an, dp);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (seg !== 7'h7F || an !== 6'h3F || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_held: seg=%h an=%h dp=%b, required 7f 3f 1", seg, an, dp);
    end
    reset = 1'b0;
    cnt0 = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      an_chk = 1'b1;
      if (an == 6'b011111) cnt0++;
      n_checks++;
      if (seg !== 7'h7F || dp !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_first_frame_blank: cycle %0d seg=%h dp=%b, required 7f 1", i, seg, dp);
      end
    end
    n_checks++;
    if (cnt0 != SD) begin
      n_fail++;
      $display("FAIL reset_scan_dwell: idx0 held %0d cycles, required %0d", cnt0, SD);
    end
  endtask

  task automatic test_directed();
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: drive(1'b0, 1'b0, 1'b0, 23, 59, 57);
        1: drive(1'b0, 1'b1, 1'b1, 7, 5, 9);
        2: drive(1'b1, 1'b0, 1'b0, 0, 0, 10);
        default: drive(1'b0, 1'b0, 1'b0, 12, 150, 34);
      endcase
      settle();
      capture();
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (!cap_seen[k] || cap_seg[k] !== exp_seg[k]) begin
          n_fail++;
          $display("FAIL directed%0d_seg idx%0d: got %h seen=%0d, required %h", t, k, cap_seg[k], cap_seen[k], exp_seg[k]);
        end
        n_checks++;
        if (cap_dp[k] !== exp_dp[k]) begin
          n_fail++;
          $display("FAIL directed%0d_dp idx%0d: got %b, required %b", t, k, cap_dp[k], exp_dp[k]);
        end
      end
    end
  endtask

  task automatic test_random(input int n);
    bit tr, h12, pm;
    int hr, mn, sc;
    for (int t = 0; t < n; t++) begin
      tr  = ($urandom_range(0, 2) == 0);
      h12 = $urandom_range(0, 1);
      pm  = $urandom_range(0, 1);
      hr  = h12 ? $urandom_range(1, 12) : $urandom_range(0, 23);
      mn  = tr ? $urandom_range(0, 99) : $urandom_range(0, 59);
      sc  = $urandom_range(0, 59);
      if ($urandom_range(0, 5) == 0) mn = $urandom_range(100, 255);
      if ($urandom_range(0, 7) == 0) sc = $urandom_range(100, 255);
      if (!tr && $urandom_range(0, 7) == 0) hr = $urandom_range(100, 255);
      drive(tr, h12, pm, hr, mn, sc);
      settle();
      capture();
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (!cap_seen[k] || cap_seg[k] !== exp_seg[k] || cap_dp[k] !== exp_dp[k]) begin
          n_fail++;
          $display("FAIL random%0d idx%0d: seg=%h dp=%b, required seg=%h dp=%b (tr=%0d h12=%0d pm=%0d %0d:%0d:%0d)",
                   t, k, cap_seg[k], cap_dp[k], exp_seg[k], exp_dp[k], tr, h12, pm, hr, mn, sc);
        end
      end
    end
  endtask

`ifdef SEG_BLINK_EN
  task automatic test_blink();
    int blanked;
    drive(1'b0, 1'b0, 1'b0, 23, 59, 57);
    settle();
    alarm_buzzer = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    blanked = 0;
    for (int f = 0; f < 8; f++) begin
      repeat (FRAME) @(negedge clk);
      if (seg == 7'h7F) blanked++;
    end
    n_checks++;
    if (blanked != 4) begin
      n_fail++;
      $display("FAIL blink_duty: %0d of 8 frames blank, required 4", blanked);
    end
    alarm_buzzer = 1'b0;
    repeat (FRAME + 2) @(negedge clk);
    capture();
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (cap_seg[k] !== exp_seg[k]) begin
        n_fail++;
        $display("FAIL blink_clear idx%0d: got %h, required %h", k, cap_seg[k], exp_seg[k]);
      end
    end
  endtask
`else
  task automatic test_blink();
    drive(1'b0, 1'b0, 1'b0, 23, 59, 57);
    settle();
    alarm_buzzer = 1'b1;
    timer_buzzer = 1'b1;
    for (int f = 0; f < 4; f++) begin
      capture();
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (cap_seg[k] !== exp_seg[k] || cap_dp[k] !== exp_dp[k]) begin
          n_fail++;
          $display("FAIL buzz_ignored frame%0d idx%0d: seg=%h dp=%b, required %h %b", f, k, cap_seg[k], cap_dp[k], exp_seg[k], exp_dp[k]);
        end
      end
    end
    alarm_buzzer = 1'b0;
    timer_buzzer = 1'b0;
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset(SD + 2);
    test_directed();
    test_reset(8);
    test_random(24);
    test_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
